chan_mbox_resp: RTL and testbench

- Memory-box side responder for the channel control logic's word-transfer requests.
- Accepts one quad-word channel request: address, per-word request mask, direction and word order.
- Services each requested word against a simple memory port and returns a ready/taken strobe per word.
- Reports non-existent-memory (NXM) and parity errors back to the channel control.

---
 rtl/chan_mbox_pkg.sv | 25 ++
 rtl/chan_wd_sel.sv | 26 ++
 rtl/chan_mbox_resp.sv | 169 ++++++++++++++++
 tb/tb_chan_mbox_resp.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_mbox_pkg.sv
// Shared definitions for the channel / memory-box word-transfer path:
// responder state encoding, default widths and the odd-parity helper.
package chan_mbox_pkg;

  localparam int ADR_W_DEF  = 22;
  localparam int DATA_W_DEF = 36;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int PAR_MAX_W  = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_MEM,
    ST_XFER,
    ST_DONE
  } mbox_state_e;

  // Parity bit that makes data plus parity hold an odd number of ones.
  function automatic logic odd_par_bit(input logic [PAR_MAX_W-1:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/chan_wd_sel.sv
// Next-word picker for a quad transfer: forward order takes the lowest
// remaining word, reverse order the highest.
module chan_wd_sel (
  input  logic [3:0] mask,
  input  logic       reverse,
  output logic [1:0] idx,
  output logic       none_left
);

  // Priority scan; the last matching index in loop order wins.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment so no latch is inferred.
    idx       = 2'd0;
    none_left = (mask == 4'b0000);
    if (reverse) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) idx = 2'(i);
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (mask[i]) idx = 2'(i);
      end
    end
  end

endmodule

// File: rtl/chan_mbox_resp.sv
// Memory-box responder: takes one quad-word channel request, runs one memory
// cycle per requested word and strobes each word back to the channel, with
// sticky NXM and parity error reporting.
module chan_mbox_resp
  import chan_mbox_pkg::*;
#(
  parameter int               ADR_W     = ADR_W_DEF,
  parameter int               DATA_W    = DATA_W_DEF,
  parameter logic [ADR_W-1:0] NXM_LIMIT = 22'h100000,
  parameter int               ACK_TMO   = 15
) (
  input  logic              clk_mbc_h,
  input  logic              mbc_reset_l,
  input  logic              ccl_chan_req_h,
  input  logic              ccl_chan_to_mem_h,
  input  logic              ccl_data_reverse_h,
  input  logic [3:0]        ccl_wd_req_h,
  input  logic [ADR_W-1:0]  ccl_chan_adr_h,
  input  logic [DATA_W-1:0] ccl_chan_data_h,
  input  logic              ccl_chan_par_h,
  output logic              mbc_busy_h,
  output logic [1:0]        mbc_wd_num_h,
  output logic              mbc_wd_ready_h,
  output logic [DATA_W-1:0] mbc_chan_data_h,
  output logic              mbc_chan_par_h,
  output logic              mbc_done_h,
  output logic              mbc_nxm_err_h,
  output logic              mbc_par_err_h,
  output logic              mem_req_h,
  output logic              mem_wr_h,
  output logic [ADR_W-1:0]  mem_adr_h,
  output logic [DATA_W-1:0] mem_wdata_h,
  input  logic              mem_ack_h,
  input  logic [DATA_W-1:0] mem_rdata_h,
  input  logic              mem_rpar_h
);

  localparam int TMO_W = $clog2(ACK_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

  mbox_state_e state_q, state_d;

  logic [ADR_W-3:0]  adr_q;      // quad address; word bits come from wd_num_q
  logic [3:0]        rem_q;      // words still to service
  logic              wr_q;
  logic              rev_q;
  logic [1:0]        wd_num_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rpar_q;
  logic              nxm_q;
  logic              par_err_q;
  logic [TMO_W-1:0]  tmo_q;      // cycles spent in MEM; zero marks MEM entry

  logic [1:0] sel_idx;
  logic       sel_none;

  logic accept;
  logic adr_nxm;
  logic wr_par_bad;
  logic mem_active;
  logic tmo_hit;
  logic rd_par_bad;

  chan_wd_sel u_wd_sel (
    .mask      (rem_q),
    .reverse   (rev_q),
    .idx       (sel_idx),
    .none_left (sel_none)
  );

  assign accept  = (state_q == ST_IDLE) && ccl_chan_req_h;
  assign adr_nxm = (ccl_chan_adr_h >= NXM_LIMIT);

  // Write parity is judged on the first MEM cycle; a bad word never reaches memory.
  assign wr_par_bad = (state_q == ST_MEM) && wr_q && (tmo_q == '0) &&
                      (odd_par_bit(PAR_MAX_W'(ccl_chan_data_h)) != ccl_chan_par_h);
  assign mem_active = (state_q == ST_MEM) && !wr_par_bad;
  assign tmo_hit    = mem_active && !mem_ack_h && (tmo_q == TMO_LAST);
  assign rd_par_bad = mem_active && !wr_q && mem_ack_h &&
                      (odd_par_bit(PAR_MAX_W'(mem_rdata_h)) != mem_rpar_h);

  // State register.
  always_ff @(posedge clk_mbc_h or negedge mbc_reset_l) begin
    if (!mbc_reset_l) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (ccl_chan_req_h) state_d = adr_nxm ? ST_DONE : ST_SELECT;
      ST_SELECT: state_d = sel_none ? ST_DONE : ST_MEM;
      ST_MEM: begin
        if (wr_par_bad || mem_ack_h) state_d = ST_XFER;
        else if (tmo_hit)            state_d = ST_DONE;
      end
      ST_XFER:   state_d = ST_SELECT;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; memory outputs are held at zero outside a live cycle.
  always_comb begin
    mbc_busy_h     = (state_q == ST_SELECT) || (state_q == ST_MEM) || (state_q == ST_XFER);
    mbc_wd_ready_h = (state_q == ST_XFER);
    mbc_done_h     = (state_q == ST_DONE);
    mbc_wd_num_h   = (state_q == ST_SELECT) ? sel_idx : wd_num_q;
    mem_req_h      = mem_active;
    mem_wr_h       = mem_active && wr_q;
    mem_adr_h      = mem_active ? {adr_q, wd_num_q} : '0;
    mem_wdata_h    = (mem_active && wr_q) ? ccl_chan_data_h : '0;
  end

  assign mbc_chan_data_h = rdata_q;
  assign mbc_chan_par_h  = rpar_q;
  assign mbc_nxm_err_h   = nxm_q;
  assign mbc_par_err_h   = par_err_q;

  // Request latching, word bookkeeping, ack timeout and error flags.
  always_ff @(posedge clk_mbc_h or negedge mbc_reset_l) begin
    if (!mbc_reset_l) begin
      adr_q     <= '0;
      rem_q     <= '0;
      wr_q      <= 1'b0;
      rev_q     <= 1'b0;
      wd_num_q  <= '0;
      rdata_q   <= '0;
      rpar_q    <= 1'b0;
      nxm_q     <= 1'b0;
      par_err_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            adr_q     <= ccl_chan_adr_h[ADR_W-1:2];
            rem_q     <= ccl_wd_req_h;
            wr_q      <= ccl_chan_to_mem_h;
            rev_q     <= ccl_data_reverse_h;
            nxm_q     <= adr_nxm;
            par_err_q <= 1'b0;
          end
        end
        ST_SELECT: begin
          wd_num_q <= sel_idx;
          tmo_q    <= '0;
        end
        ST_MEM: begin
          if (mem_active && !mem_ack_h) tmo_q <= tmo_q + TMO_W'(1);
          if (tmo_hit) nxm_q <= 1'b1;
          if (mem_active && mem_ack_h && !wr_q) begin
            rdata_q <= mem_rdata_h;
            rpar_q  <= mem_rpar_h;
          end
          if (wr_par_bad || rd_par_bad) par_err_q <= 1'b1;
        end
        ST_XFER: rem_q[wd_num_q] <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chan_mbox_resp.sv
// Scoreboard bench for chan_mbox_resp: a behavioural memory and channel drive
// the responder; expected word strobes and memory writes are queued when each
// request is issued and retired as the responder produces them.
module tb_chan_mbox_resp;

  logic        clk_mbc_h;
  logic        mbc_reset_l;
  logic        ccl_chan_req_h;
  logic        ccl_chan_to_mem_h;
  logic        ccl_data_reverse_h;
  logic [3:0]  ccl_wd_req_h;
  logic [21:0] ccl_chan_adr_h;
  logic [35:0] ccl_chan_data_h;
  logic        ccl_chan_par_h;
  logic        mbc_busy_h;
  logic [1:0]  mbc_wd_num_h;
  logic        mbc_wd_ready_h;
  logic [35:0] mbc_chan_data_h;
  logic        mbc_chan_par_h;
  logic        mbc_done_h;
  logic        mbc_nxm_err_h;
  logic        mbc_par_err_h;
  logic        mem_req_h;
  logic        mem_wr_h;
  logic [21:0] mem_adr_h;
  logic [35:0] mem_wdata_h;
  logic        mem_ack_h;
  logic [35:0] mem_rdata_h;
  logic        mem_rpar_h;

  chan_mbox_resp dut (
    .clk_mbc_h          (clk_mbc_h),
    .mbc_reset_l        (mbc_reset_l),
    .ccl_chan_req_h     (ccl_chan_req_h),
    .ccl_chan_to_mem_h  (ccl_chan_to_mem_h),
    .ccl_data_reverse_h (ccl_data_reverse_h),
    .ccl_wd_req_h       (ccl_wd_req_h),
    .ccl_chan_adr_h     (ccl_chan_adr_h),
    .ccl_chan_data_h    (ccl_chan_data_h),
    .ccl_chan_par_h     (ccl_chan_par_h),
    .mbc_busy_h         (mbc_busy_h),
    .mbc_wd_num_h       (mbc_wd_num_h),
    .mbc_wd_ready_h     (mbc_wd_ready_h),
    .mbc_chan_data_h    (mbc_chan_data_h),
    .mbc_chan_par_h     (mbc_chan_par_h),
    .mbc_done_h         (mbc_done_h),
    .mbc_nxm_err_h      (mbc_nxm_err_h),
    .mbc_par_err_h      (mbc_par_err_h),
    .mem_req_h          (mem_req_h),
    .mem_wr_h           (mem_wr_h),
    .mem_adr_h          (mem_adr_h),
    .mem_wdata_h        (mem_wdata_h),
    .mem_ack_h          (mem_ack_h),
    .mem_rdata_h        (mem_rdata_h),
    .mem_rpar_h         (mem_rpar_h)
  );

  logic [103:0] outs;
  assign outs = {mbc_busy_h, mbc_wd_num_h, mbc_wd_ready_h, mbc_chan_data_h, mbc_chan_par_h,
                 mbc_done_h, mbc_nxm_err_h, mbc_par_err_h, mem_req_h, mem_wr_h,
                 mem_adr_h, mem_wdata_h};

  initial clk_mbc_h = 1'b0;
  always #5 clk_mbc_h = ~clk_mbc_h;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  wd;
    bit          chk;
    logic [35:0] data;
    logic        par;
  } rdy_t;

  typedef struct {
    logic [21:0] adr;
    logic [35:0] data;
  } wr_t;

  rdy_t rdy_q[$];
  wr_t  wr_q[$];

  // Behavioural memory and channel knobs.
  int          ack_delay  = 0;
  bit          bad_rd_en  = 0;
  logic [21:0] bad_rd_adr = '0;
  bit          bad_wr_en  = 0;
  logic [1:0]  bad_wr_wd  = '0;
  int          req_cycles = 0;
  logic [3:0]  words_seen = '0;

  function automatic logic [35:0] mem_word(input logic [21:0] a);
    return {14'h2A5, a};
  endfunction

  function automatic logic [35:0] chan_word(input logic [1:0] wd);
    return {34'h0ABCD123, wd};
  endfunction

  function automatic logic good_par(input logic [35:0] d);
    return ~(^d);
  endfunction

  // Memory: acks after ack_delay waiting cycles, serves reads, checks writes.
  initial begin
    int wait_cnt;
    wr_t w;
    wait_cnt    = 0;
    mem_ack_h   = 1'b0;
    mem_rdata_h = '0;
    mem_rpar_h  = 1'b0;
    forever begin
      @(negedge clk_mbc_h);
      if (mem_req_h === 1'b1) begin
        req_cycles++;
        words_seen[mem_adr_h[1:0]] = 1'b1;
        if (wait_cnt >= ack_delay) begin
          mem_ack_h = 1'b1;
          if (mem_wr_h === 1'b1) begin
            if (wr_q.size() == 0) begin
              check("wr_unexpected", wr_q.size(), 1);
            end else begin
              w = wr_q.pop_front();
              check("wr_adr", mem_adr_h, w.adr);
              check("wr_data", mem_wdata_h, w.data);
            end
          end else begin
            mem_rdata_h = mem_word(mem_adr_h);
            mem_rpar_h  = good_par(mem_word(mem_adr_h)) ^ (bad_rd_en && (mem_adr_h == bad_rd_adr));
          end
        end else begin
          mem_ack_h = 1'b0;
        end
        wait_cnt++;
      end else begin
        wait_cnt  = 0;
        mem_ack_h = 1'b0;
      end
    end
  end

  // Channel write data follows the word number the responder presents.
  initial begin
    ccl_chan_data_h = '0;
    ccl_chan_par_h  = 1'b0;
    forever begin
      @(posedge clk_mbc_h);
      #1;
      ccl_chan_data_h = chan_word(mbc_wd_num_h);
      ccl_chan_par_h  = good_par(chan_word(mbc_wd_num_h)) ^ (bad_wr_en && (mbc_wd_num_h == bad_wr_wd));
    end
  end

  // Word strobe monitor: each pulse retires the oldest expected word.
  initial begin
    rdy_t r;
    forever begin
      @(negedge clk_mbc_h);
      if (mbc_wd_ready_h === 1'b1) begin
        if (rdy_q.size() == 0) begin
          check("rdy_unexpected", rdy_q.size(), 1);
        end else begin
          r = rdy_q.pop_front();
          check("rdy_wd", mbc_wd_num_h, r.wd);
          check("rdy_busy", mbc_busy_h, 1);
          if (r.chk) begin
            check("rdy_data", mbc_chan_data_h, r.data);
            check("rdy_par", mbc_chan_par_h, r.par);
          end
        end
      end
    end
  end

  task automatic push_expect(input bit wr, input bit rev, input logic [3:0] mask,
                             input logic [21:0] adr);
    rdy_t r;
    wr_t  w;
    logic [21:0] a;
    for (int j = 0; j < 4; j++) begin
      logic [1:0] wd;
      wd = rev ? 2'(3 - j) : 2'(j);
      if (mask[wd]) begin
        a = {adr[21:2], wd};
        r.wd = wd;
        if (wr) begin
          r.chk = 0; r.data = '0; r.par = 1'b0;
          if (!(bad_wr_en && wd == bad_wr_wd)) begin
            w.adr = a; w.data = chan_word(wd);
            wr_q.push_back(w);
          end
        end else begin
          r.chk  = 1;
          r.data = mem_word(a);
          r.par  = good_par(mem_word(a)) ^ (bad_rd_en && (a == bad_rd_adr));
        end
        rdy_q.push_back(r);
      end
    end
  endtask

  // One request from accept through done; exp_lat < 0 means "done within 2 cycles".
  task automatic run_txn(input string name, input bit wr, input bit rev, input logic [3:0] mask,
                         input logic [21:0] adr, input bit push_exp, input int exp_lat,
                         input bit exp_nxm, input bit exp_par, input int exp_req,
                         input logic [3:0] exp_words);
    bit imm_nxm;
    bit got;
    int lat;
    logic busy_at_done;
    imm_nxm = (adr >= 22'h100000);
    if (push_exp && !imm_nxm) push_expect(wr, rev, mask, adr);
    @(posedge clk_mbc_h);
    #1;
    req_cycles         = 0;
    words_seen         = '0;
    ccl_chan_to_mem_h  = wr;
    ccl_data_reverse_h = rev;
    ccl_wd_req_h       = mask;
    ccl_chan_adr_h     = adr;
    ccl_chan_req_h     = 1'b1;
    got = 0; lat = -1; busy_at_done = 1'bx;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk_mbc_h);
      if (k == 0) check({name, "_idle_busy"}, mbc_busy_h, 0);
      if (k == 1) begin
        check({name, "_nxm_at_accept"}, mbc_nxm_err_h, imm_nxm);
        check({name, "_par_cleared"}, mbc_par_err_h, 0);
      end
      if (mbc_done_h === 1'b1) begin
        got = 1; lat = k; busy_at_done = mbc_busy_h;
        ccl_chan_req_h = 1'b0;
      end else if (k == 1) begin
        // Latched request: later input changes must have no effect.
        ccl_wd_req_h       = ~mask;
        ccl_data_reverse_h = ~rev;
        ccl_chan_to_mem_h  = ~wr;
        ccl_chan_adr_h     = adr ^ 22'h0F0F0;
      end
    end
    ccl_chan_req_h = 1'b0;
    check({name, "_done_seen"}, got, 1);
    if (exp_lat >= 0) check({name, "_latency"}, lat, exp_lat);
    else              check({name, "_latency_le2"}, (lat >= 1 && lat <= 2), 1);
    check({name, "_busy_at_done"}, busy_at_done, 0);
    check({name, "_nxm"}, mbc_nxm_err_h, exp_nxm);
    check({name, "_par"}, mbc_par_err_h, exp_par);
    check({name, "_mem_cycles"}, req_cycles, exp_req);
    check({name, "_words_seen"}, words_seen, exp_words);
    @(negedge clk_mbc_h);
    check({name, "_nxm_sticky"}, mbc_nxm_err_h, exp_nxm);
    check({name, "_par_sticky"}, mbc_par_err_h, exp_par);
    check({name, "_rdy_left"}, rdy_q.size(), 0);
    check({name, "_wr_left"}, wr_q.size(), 0);
    rdy_q.delete();
    wr_q.delete();
  endtask

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int done_cnt;
    mbc_reset_l        = 1'b0;
    ccl_chan_req_h     = 1'b0;
    ccl_chan_to_mem_h  = 1'b0;
    ccl_data_reverse_h = 1'b0;
    ccl_wd_req_h       = '0;
    ccl_chan_adr_h     = '0;
    repeat (2) @(negedge clk_mbc_h);
    check("reset_outs", outs, 0);
    mbc_reset_l = 1'b1;

    run_txn("rd_fwd",  0, 0, 4'b1111, 22'o1000,    1, 14, 0, 0, 4,  4'b1111);
    run_txn("wr_rev",  1, 1, 4'b1010, 22'h000400,  1, 8,  0, 0, 2,  4'b1010);
    run_txn("rd_rev",  0, 1, 4'b0110, 22'h000123,  1, 8,  0, 0, 2,  4'b0110);
    run_txn("nxm",     0, 0, 4'b1111, 22'h100004,  1, -1, 1, 0, 0,  4'b0000);
    run_txn("after_nxm", 0, 0, 4'b0001, 22'h000040, 1, 5, 0, 0, 1,  4'b0001);

    ack_delay = 99;
    run_txn("tmo",     0, 0, 4'b0011, 22'h000300,  0, 17, 1, 0, 15, 4'b0001);
    ack_delay = 0;

    bad_rd_en = 1; bad_rd_adr = 22'h000501;
    run_txn("rd_par",  0, 0, 4'b0010, 22'h000500,  1, 5,  0, 1, 1,  4'b0010);
    bad_rd_en = 0;

    bad_wr_en = 1; bad_wr_wd = 2'd2;
    run_txn("wr_par",  1, 0, 4'b0110, 22'h000600,  1, 8,  0, 1, 1,  4'b0010);
    bad_wr_en = 0;

    // Reset while a memory cycle is outstanding.
    ack_delay = 99;
    @(posedge clk_mbc_h);
    #1;
    ccl_chan_to_mem_h  = 1'b0;
    ccl_data_reverse_h = 1'b0;
    ccl_wd_req_h       = 4'b0001;
    ccl_chan_adr_h     = 22'h000700;
    ccl_chan_req_h     = 1'b1;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk_mbc_h);
      if (mem_req_h === 1'b1) got = 1;
    end
    check("rstmid_memreq_seen", got, 1);
    mbc_reset_l    = 1'b0;
    ccl_chan_req_h = 1'b0;
    #1;
    check("rstmid_outs", outs, 0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk_mbc_h);
      if (mbc_done_h !== 1'b0) done_cnt++;
    end
    check("rstmid_no_done", done_cnt, 0);
    mbc_reset_l = 1'b1;
    ack_delay   = 0;
    rdy_q.delete();
    wr_q.delete();

    run_txn("empty",   0, 0, 4'b0000, 22'h000800,  1, 2,  0, 0, 0,  4'b0000);
    run_txn("rd_post", 0, 0, 4'b0001, 22'h000010,  1, 5,  0, 0, 1,  4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
